// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read side and UART line bundle for uart_tx_fifo_drain.
// The slave modport is the drain engine; the master modport is the FIFO/line side.
interface uart_tx_fifo_drain_if;
  logic        i_empty;
  logic        o_rd_en;
  logic [7:0]  i_rd_data;
  logic        o_tx;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_tx_cnt;

  modport slave (
    input  i_empty,
    input  i_rd_data,
    output o_rd_en,
    output o_tx,
    output o_busy,
    output o_done,
    output o_tx_cnt
  );

  modport master (
    output i_empty,
    output i_rd_data,
    input  o_rd_en,
    input  o_tx,
    input  o_busy,
    input  o_done,
    input  o_tx_cnt
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a FIFO and frames them onto a UART line (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined). All outputs come straight from flops.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  uart_tx_fifo_drain_if.slave bus
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam int          IDX_W     = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  state_t              state_r, state_nxt_s;
  logic [15:0]         baud_r, baud_nxt_s;
  logic [IDX_W-1:0]    bit_idx_r, bit_idx_nxt_s;
  logic [DATA_W-1:0]   shift_r, shift_nxt_s;
  logic                tx_r, tx_nxt_s;
  logic                rd_en_r, rd_en_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic [15:0]         tx_cnt_r, tx_cnt_nxt_s;
  logic                baud_tc_s;

  assign baud_tc_s = (baud_r == BAUD_LAST);

  // Next-state logic; i_empty only matters in IDLE so a lagging flag cannot double-pop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (!bus.i_empty) state_nxt_s = ST_POP;   else state_nxt_s = ST_IDLE;
      ST_POP:   state_nxt_s = ST_LOAD;
      ST_LOAD:  state_nxt_s = ST_START;
      ST_START: if (baud_tc_s)    state_nxt_s = ST_DATA;  else state_nxt_s = ST_START;
      ST_DATA: begin
        if (baud_tc_s && (bit_idx_r == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_tc_s) state_nxt_s = ST_STOP; else state_nxt_s = ST_PARITY;
`endif
      ST_STOP:  if (baud_tc_s)    state_nxt_s = ST_IDLE;  else state_nxt_s = ST_STOP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values, derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    baud_nxt_s    = 16'd0;
    bit_idx_nxt_s = {IDX_W{1'b0}};
    shift_nxt_s   = shift_r;
    tx_nxt_s      = 1'b1;

    if ((state_nxt_s != state_r) || baud_tc_s) begin
      baud_nxt_s = 16'd0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_POP) || (state_r == ST_LOAD)) begin
      baud_nxt_s = 16'd0;
    end else begin
      baud_nxt_s = baud_r + 16'd1;
    end

    if ((state_r == ST_DATA) && baud_tc_s) begin
      bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
    end else if (state_r == ST_DATA) begin
      bit_idx_nxt_s = bit_idx_r;
    end else begin
      bit_idx_nxt_s = {IDX_W{1'b0}};
    end

    if (state_r == ST_LOAD) begin
      shift_nxt_s = bus.i_rd_data;
    end else begin
      shift_nxt_s = shift_r;
    end

    case (state_nxt_s)
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = shift_nxt_s[bit_idx_nxt_s];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt_s = even_parity(shift_r);
`endif
      default:   tx_nxt_s = 1'b1;
    endcase

    rd_en_nxt_s  = (state_nxt_s == ST_POP);
    busy_nxt_s   = (state_nxt_s != ST_IDLE);
    done_nxt_s   = (state_nxt_s == ST_STOP) && (baud_nxt_s == BAUD_LAST);
    tx_cnt_nxt_s = done_nxt_s ? (tx_cnt_r + 16'd1) : tx_cnt_r;
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= ST_IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= {IDX_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      tx_r      <= 1'b1;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      tx_cnt_r  <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      baud_r    <= baud_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      tx_r      <= tx_nxt_s;
      rd_en_r   <= rd_en_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      tx_cnt_r  <= tx_cnt_nxt_s;
    end
  end

  assign bus.o_tx     = tx_r;
  assign bus.o_rd_en  = rd_en_r;
  assign bus.o_busy   = busy_r;
  assign bus.o_done   = done_r;
  assign bus.o_tx_cnt = tx_cnt_r;

endmodule
